// File: rtl/fir_mac_acc.sv
// FIR tap accumulator behind a pipelined multiplier: aligns tags with products and emits rounded, saturated sums.
// Optional saturation counter port sat_cnt is built when FIR_MAC_SAT_CNT_EN is defined.
//   state | meaning
//   IDLE  | no partial sum in progress
//   ACC   | partial sum held in acc_q, waiting for the last tap
module fir_mac_acc #(
  parameter int MUL_LAT = 3,
  parameter int PSIZE   = 32,
  parameter int ACC_W   = 40,
  parameter int SHIFT   = 15,
  parameter int OUT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    tag_valid,
  input  logic                    tag_first,
  input  logic                    tag_last,
  input  logic signed [PSIZE-1:0] p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    busy,
  output logic                    ovf_err,
  input  logic                    clr_err
`ifdef FIR_MAC_SAT_CNT_EN
  ,
  output logic [15:0]             sat_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  localparam logic signed [ACC_W:0] RND  = ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [2:0] tag_a;  // {valid, first, last} aligned with p

  generate
    if (MUL_LAT == 0) begin : g_direct
      assign tag_a = {tag_valid, tag_first, tag_last};
    end else begin : g_pipe
      logic [2:0] pipe_q [MUL_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
        end else if (ce) begin
          pipe_q[0] <= {tag_valid, tag_first, tag_last};
          for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign tag_a = pipe_q[MUL_LAT-1];
    end
  endgenerate

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]   out_data_q, out_data_d;
  logic                      ovf_q, ovf_d;

  logic                      beat, res_done, load, drop, sat;
  logic signed [ACC_W-1:0]   p_ext, sum;
  logic signed [ACC_W:0]     rnd, shf;
  logic signed [OUT_W-1:0]   res;

  assign beat     = ce & tag_a[2];
  assign res_done = beat & tag_a[0];
  assign p_ext    = ACC_W'(p);
  assign sum      = (tag_a[1] ? '0 : acc_q) + p_ext;

  // One extra bit keeps the rounding add from wrapping near the positive limit.
  always_comb begin
    rnd = {sum[ACC_W-1], sum} + RND;
    shf = rnd >>> SHIFT;
    sat = 1'b0;
    res = shf[OUT_W-1:0];
    if (shf > MAXV) begin
      res = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (shf < MINV) begin
      res = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (beat) begin
      if (tag_a[0])      state_d = IDLE;
      else if (tag_a[1]) state_d = ACC;
    end
  end

  always_comb begin
    busy = (state_q == ACC);
  end

  assign load = res_done & (~out_valid_q | out_ready);
  assign drop = res_done & out_valid_q & ~out_ready;

  always_comb begin
    acc_d = acc_q;
    if (beat) acc_d = tag_a[0] ? '0 : sum;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = res;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_err) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ovf_err   = ovf_q;

`ifdef FIR_MAC_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic        sat_inc;

  // Dropped results still count; a clear coinciding with a clamp keeps that clamp.
  assign sat_inc = res_done & sat;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr_err)                          sat_cnt_d = {15'd0, sat_inc};
    else if (sat_inc && sat_cnt_q != '1)  sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat = sat;
`endif

endmodule

// File: doc/fir_mac_acc.md
FIR_MAC_ACC -- requirements
Module: fir_mac_acc

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, giving the pipeline latency in ce-cycles of the upstream mul instance; legal range 0..5.
REQ-002 SHALL have parameter PSIZE, default 32, giving the product width.
REQ-003 SHALL have parameter ACC_W, default 40, giving the accumulator width; ACC_W >= PSIZE.
REQ-004 SHALL have parameter SHIFT, default 15, giving the output scaling right-shift; legal range 0..ACC_W-2.
REQ-005 SHALL have parameter OUT_W, default 16, giving the output sample width.
REQ-006 SHALL have port clk, input, 1 bit: clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port ce, input, 1 bit: pipeline enable, shared with the mul ce.
REQ-009 SHALL have port tag_valid, input, 1 bit: an a/b pair is issued to mul this cycle.
REQ-010 SHALL have port tag_first, input, 1 bit: the pair is the first tap of a sum.
REQ-011 SHALL have port tag_last, input, 1 bit: the pair is the last tap of a sum.
REQ-012 SHALL have port p, input, PSIZE bits: signed product from mul.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-015 SHALL have port out_data, output, OUT_W bits: signed, rounded, saturated sample.
REQ-016 SHALL have port busy, output, 1 bit: a partial sum is in progress (state ACC).
REQ-017 SHALL have port ovf_err, output, 1 bit: sticky flag, a result was dropped.
REQ-018 SHALL have port clr_err, input, 1 bit: synchronous clear of ovf_err.

Function
REQ-019 SHALL delay {tag_valid, tag_first, tag_last} through MUL_LAT registers that advance only when ce=1, so the delayed tag is aligned with p; MUL_LAT=0 is a direct wire.
REQ-020 An aligned beat SHALL be an aligned tag_valid=1 with ce=1; there SHALL be no accumulator or state change when ce=0.
REQ-021 On an aligned beat, sum SHALL be (aligned_first ? 0 : acc) + sign-extended p, computed modulo 2^ACC_W with no saturation inside the accumulator.
REQ-022 SHALL use two states, IDLE and ACC:
  - IDLE -> ACC on a beat with first=1 and last=0.
  - ACC -> IDLE on a beat with last=1.
  - first=1 while in ACC restarts the sum and discards the partial sum.
  - A beat with last=0 and first=0 in IDLE accumulates onto acc.
REQ-023 On a beat with last=0, acc SHALL be loaded with sum.
REQ-024 On a beat with last=1, acc SHALL clear to 0 and the result SHALL be computed from sum.
REQ-025 Result SHALL be round-half-up then saturate:
  - (sum + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT; no rounding add when SHIFT=0.
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-026 The result SHALL register into out_data/out_valid one clk after the last beat; latency from tag_last issue to out_valid SHALL be MUL_LAT+1 cycles with ce held at 1.
REQ-027 out_valid SHALL clear on out_valid && out_ready unless a new result loads in the same cycle, in which case the new result SHALL be loaded and out_valid SHALL stay 1 with no drop.
REQ-028 If a result completes while out_valid=1 and out_ready=0, the new result SHALL be dropped, out_data SHALL hold its value, and ovf_err SHALL be set.
REQ-029 A ovf_err set and clr_err in the same cycle SHALL leave ovf_err=1.
REQ-030 busy SHALL equal (state==ACC).

Reset
REQ-031 rst SHALL asynchronously clear the tag pipeline, acc, state (to IDLE), out_valid, out_data, ovf_err and sat_cnt to 0.
REQ-032 rst asserted mid-sum SHALL discard the partial sum and any in-flight tags; no result SHALL emerge from them after release.

Configuration
REQ-033 With macro FIR_MAC_SAT_CNT_EN defined:
  - Output port sat_cnt [15:0] SHALL be present.
  - It SHALL increment on every result clamped by REQ-025, including dropped results, and SHALL saturate at 0xFFFF.
  - clr_err SHALL also clear it.
REQ-034 Without FIR_MAC_SAT_CNT_EN, the sat_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Single tap, first=last=1, a=0x4000, b=0x4000, p=0x10000000 -> out_data=0x2000, out_valid exactly 4 cycles after issue.
REQ-036 Four taps of 0x7FFF*0x7FFF, sum 0xFFFC0004 -> out_data=0x7FFF, and with the macro sat_cnt=1.
REQ-037 Single tap a=0x8000, b=0x7FFF -> out_data=0x8001; single tap a=1, b=0x4000 -> 0x0001; single tap a=1, b=0x3FFF -> 0x0000.
REQ-038 out_ready=0, two back-to-back single-tap results 0x2000 then 0x1000 -> out_data stays 0x2000, ovf_err=1; clr_err pulse -> ovf_err=0.
REQ-039 rst pulsed after 2 of 4 taps, then a new single-tap 0x4000*0x4000 -> only 0x2000 appears, busy=0 during reset.
REQ-040 ce=0 for 3 cycles mid-sum with p held constant -> result equals the ce=1 run, latency stretched by 3 cycles.
